// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its digit cells.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the count chain: increments on inc, wraps 9 -> 0,
// carry flags the digit sitting at 9 so the next digit can be enabled.
module bcd_digit_cell
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q, digit_d;

  // clear beats increment; any value at or above 9 wraps so 10..15 never appear
  always_comb begin
    digit_d = digit_q;
    if (clr)      digit_d = 4'd0;
    else if (inc) digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
  end

  // digit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) digit_q <= 4'd0;
    else          digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign carry = (digit_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: command FSM, count prescaler, cascaded BCD digit
// chain, lap snapshot and sticky overflow. All outputs come from registers.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    overflow
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_e               state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    ovf_q, ovf_d;
  logic                    active, tick;
  logic [4*NUM_DIGITS-1:0] cnt;
  logic [NUM_DIGITS-1:0]   carry;
  logic [NUM_DIGITS:0]     en;

  assign active = (state_q == RUN) || (state_q == LAP);
  assign tick   = active && (pre_q == PRE_LAST);

  // Digit k is enabled by tick and the carries of every lower digit.
  assign en[0] = tick;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (en[g]),
      .digit   (cnt[4*g +: 4]),
      .carry   (carry[g])
    );
    assign en[g+1] = en[g] & carry[g];
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: clear over start_stop over lap; lap only matters in RUN/LAP
  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        LAP:     state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end else if (lap) begin
      if (state_q == RUN)      state_d = LAP;
      else if (state_q == LAP) state_d = RUN;
    end
  end

  // outputs decoded from registered state, snapshot and live count
  always_comb begin
    running = active;
    display = (state_q == LAP) ? snap_q : cnt;
  end

  // prescaler, lap snapshot and overflow next-state
  always_comb begin
    pre_d  = pre_q;
    snap_d = snap_q;
    ovf_d  = ovf_q | en[NUM_DIGITS];
    if (clear) begin
      pre_d  = '0;
      snap_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (state_q == IDLE) pre_d = '0;
      else if (active)     pre_d = tick ? '0 : pre_q + PW'(1);
      // freeze the count seen in the cycle the entering lap pulse is sampled
      if (state_q == RUN && state_d == LAP) snap_d = cnt;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count    = cnt;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus random bench for stopwatch_ctrl against an integer-valued model.
module tb_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int ND   = 2;
  localparam int W    = 4 * ND;
  localparam int MAXV = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [W-1:0] count, display;
  logic         running, overflow;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .count      (count),
    .display    (display),
    .running    (running),
    .overflow   (overflow)
  );

  int n_cmp = 0, n_err = 0;
  int m_st, m_pre, m_cnt, m_snap;
  bit m_ovf;

  function automatic logic [31:0] bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pre = 0; m_cnt = 0; m_snap = 0; m_ovf = 0;
  endtask

  // one clock of the reference behaviour, applied to the pre-edge model state
  task automatic model_step(input bit ss, input bit lp, input bit cl);
    bit act, tk;
    act = (m_st == M_RUN) || (m_st == M_LAP);
    tk  = act && (m_pre == TD - 1);
    if (cl) begin
      model_reset();
    end else begin
      if (ss) begin
        m_st = (m_st == M_RUN || m_st == M_LAP) ? M_PAUSE : M_RUN;
      end else if (lp && m_st == M_RUN) begin
        m_st = M_LAP; m_snap = m_cnt;
      end else if (lp && m_st == M_LAP) begin
        m_st = M_RUN;
      end
      if (tk) begin
        m_cnt = (m_cnt + 1) % MAXV;
        if (m_cnt == 0) m_ovf = 1;
      end
      if (!act && m_st != M_RUN && m_pre != 0 && ss == 0) m_pre = m_pre; // paused: hold
      if (act) m_pre = (m_pre + 1) % TD;
      else if (m_st == M_IDLE) m_pre = 0;
    end
  endtask

  task automatic check_all(input string tag);
    bit dok;
    dok = 1;
    for (int k = 0; k < ND; k++) if (count[4*k +: 4] > 4'd9) dok = 0;
    chk({tag, "_count"},   32'(count),   bcd(m_cnt));
    chk({tag, "_display"}, 32'(display), (m_st == M_LAP) ? bcd(m_snap) : bcd(m_cnt));
    chk({tag, "_running"}, 32'(running), 32'((m_st == M_RUN) || (m_st == M_LAP)));
    chk({tag, "_overflow"},32'(overflow),32'(m_ovf));
    chk({tag, "_digits"},  32'(dok),     32'(1));
  endtask

  task automatic cyc(input bit ss, input bit lp, input bit cl);
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    model_step(ss, lp, cl);
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    check_all("cyc");
  endtask

  initial begin
    int held, saved, gap, prev;
    bit ss, lp, cl;

    // reset
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset_state", 32'(dut.state_q), 32'(M_IDLE));
    reset_n = 1'b1;

    // basic count
    cyc(1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0);
      if (i == 4)  chk("basic_c4",  32'(count), 32'h01);
      if (i == 40) chk("basic_c40", 32'(count), 32'h10);
    end

    // run up to 99, then one more tick
    for (int i = 0; i < 2000 && m_cnt != 99; i++) cyc(0, 0, 0);
    repeat (TD) cyc(0, 0, 0);
    chk("wrap_count", 32'(count),    32'h00);
    chk("wrap_ovf",   32'(overflow), 32'(1));
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'(1));
    cyc(0, 0, 1);
    chk("ovf_clear",  32'(overflow), 32'(0));
    chk("clr_count",  32'(count),    32'h00);

    // lap
    cyc(1, 0, 0);
    for (int i = 0; i < 2000 && m_cnt != 12; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (11) cyc(0, 0, 0);
    chk("lap_count",   32'(count),   32'h15);
    chk("lap_display", 32'(display), 32'h12);
    chk("lap_running", 32'(running), 32'(1));
    cyc(0, 1, 0);
    chk("lap_release", 32'(display), bcd(m_cnt));

    // pause mid-tick, then resume
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    held  = m_pre;
    saved = m_cnt;
    repeat (20) cyc(0, 0, 0);
    chk("pause_count",   32'(count),   bcd(saved));
    chk("pause_running", 32'(running), 32'(0));
    cyc(1, 0, 0);
    prev = 32'(count);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      gap++;
      if (32'(count) != prev) break;
    end
    chk("resume_gap", 32'(gap), 32'(TD - held));

    // priorities
    cyc(1, 0, 1);
    chk("prio_clr_state", 32'(dut.state_q), 32'(M_IDLE));
    chk("prio_clr_count", 32'(count),       32'h00);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("prio_ss_lap", 32'(dut.state_q), 32'(M_PAUSE));
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_state", 32'(dut.state_q), 32'(M_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // random command traffic
    for (int i = 0; i < 800; i++) begin
      ss = ($urandom_range(0, 11) == 0);
      lp = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 79) == 0);
      cyc(ss, lp, cl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences a cascaded chain of BCD digit counters as a start/stop/lap stopwatch. A parameterised prescaler generates a count tick. Single-cycle command pulses drive a four-state FSM. The block exposes the live count and a display value that freezes during lap. It sits between the debounced push-button pulse generators and the seven-segment display driver.

## Interface
- TICK_DIV, 1_000_000: clk cycles per count tick; legal values are 2 and above.
- NUM_DIGITS, 4: number of BCD digits in the chain; legal values are 1 and above.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start_stop  input  1  single-cycle command pulse: start, pause or resume.
- lap  input  1  single-cycle command pulse: freeze or release the display.
- clear  input  1  single-cycle command pulse: return to zero and IDLE.
- count  output  4*NUM_DIGITS  live BCD count; digit 0 is in bits [3:0].
- display  output  4*NUM_DIGITS  value for the display driver.
- running  output  1  high when the state is RUN or LAP.
- overflow  output  1  sticky flag; set when the count wraps past all-9s.

## Operation
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: on start_stop, go to RUN.
  - RUN: on start_stop, go to PAUSE; on lap, go to LAP.
  - PAUSE: on start_stop, go to RUN.
  - LAP: on start_stop, go to PAUSE; on lap, go to RUN.
  - Any state: on clear, go to IDLE.
- Command priority within one cycle: clear first, then start_stop, then lap.
- lap is ignored in IDLE and PAUSE.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - Advances only in cycles where the registered state is RUN or LAP.
  - Wraps from TICK_DIV-1 to 0.
  - tick is asserted in the cycle where the prescaler equals TICK_DIV-1 and the state is RUN or LAP.
  - Holds its value in PAUSE.
  - Zeroed in IDLE and on clear.
- Digit chain:
  - Digit k increments on tick when digits 0 to k-1 all equal 9.
  - Each digit wraps from 9 to 0; no digit ever holds a value of 10 to 15.
- Full-scale wrap: a tick while every digit is 9 sets every digit to 0 and sets overflow. Counting continues.
- overflow clears only on clear or reset.
- display:
  - Equals count in every state except LAP.
  - In LAP, display holds the count value present in the cycle the entering lap pulse was sampled.
  - The count continues to advance underneath the frozen display.
- clear zeroes the count, the prescaler, overflow and the lap snapshot.

## Timing
- Reset values: state IDLE; count, display and prescaler all 0; running 0; overflow 0.
- A command sampled in cycle n takes effect in the state from cycle n+1.
- The cycle in which a command is sampled still counts under the old state.
- First increment after start:
  - From IDLE: the digits change at the edge ending the TICK_DIV-th RUN cycle.
  - After a resume: the interval is shorter, by the prescaler value held in PAUSE.
- Every tick that falls in a RUN or LAP cycle lands; a pause is never lost, it only delays the count.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- reset_n asserted mid-count forces the reset values immediately, independent of clk.
- A clear in the same cycle as a tick: the clear wins and the count ends at 0.

## Structure
- Package stopwatch_pkg holds:
  - the state typedef, with fixed encoding IDLE=0, RUN=1, PAUSE=2, LAP=3;
  - the constant BCD_MAX = 4'd9.
- Sub-module bcd_digit_cell, one instance per digit from a generate loop:
  - inputs: clk, reset_n, clr, inc;
  - outputs: 4-bit digit, and carry, which is high when digit == 9.
  - It updates on the rising edge.
- The chain enable for digit k is tick ANDed with the carries of digits 0 to k-1.
- The top module contains the FSM, the prescaler, the lap snapshot register and the overflow flag.

## Test plan
All scenarios use TICK_DIV=4 and NUM_DIGITS=2 unless stated otherwise.
- Reset check: assert reset_n low between clock edges, then release. Required: count=0x00, display=0x00, running=0, overflow=0, state IDLE.
- Basic count: pulse start_stop, then run 40 cycles. Required: count=0x01 after cycle 4 and count=0x10 after cycle 40; no digit ever reads above 9.
- Wrap and overflow: run to count 0x99, then one more tick. Required: count=0x00 and overflow=1. overflow stays 1 through a pause/resume cycle and drops only on clear.
- Lap: pulse lap at count 0x12, then wait 3 ticks. Required: count=0x15, display=0x12, running=1. Pulse lap again. Required: display tracks count from the next cycle.
- Pause: pulse start_stop mid-tick, then wait 20 cycles. Required: count and prescaler unchanged, running=0. Resume. Required: the next increment arrives after 4 minus the held prescaler value of RUN cycles.
- Priorities:
  - Pulse clear and start_stop together while in RUN. Required: IDLE, count=0x00.
  - Pulse start_stop and lap together while in RUN. Required: PAUSE.
  - Drop reset_n mid-LAP. Required: immediate reset values.
